instr_loader: RTL

//  Writer side of the 16-bit instruction word consumed by the control decoder.

---
 rtl/instr_loader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: packs high/low byte pairs into 16-bit words,
// screens opcodes, writes imem from address 0 and holds the CPU until a clean load.
module instr_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        err_opc,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    StIdle,
    StHi,
    StLo,
    StWr,
    StDone,
    StErr
  } state_e;

  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [3:0]        err_opc_q, err_opc_d;
  logic              hold_q, hold_d;

  logic              xfer;
  logic              len_ok;
  logic              len_big;
  logic              opc_legal;
  logic [ADDR_W:0]   cnt_inc;

  assign in_ready  = (state_q == StHi) || (state_q == StLo);
  assign xfer      = in_valid && in_ready;
  assign len_ok    = (len != '0) && (len <= MaxLen);
  assign len_big   = (len > MaxLen);
  // Only opcodes 4'hD and 4'hE are undefined.
  assign opc_legal = (in_data[7:4] != 4'hD) && (in_data[7:4] != 4'hE);
  assign cnt_inc   = cnt_q + (ADDR_W + 1)'(1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    err_opc_d = err_opc_q;
    hold_d    = hold_q;

    unique case (state_q)
      StIdle, StErr: begin
        if (start) begin
          if (len_ok) begin
            len_d     = len;
            cnt_d     = '0;
            addr_d    = '0;
            err_d     = 1'b0;
            err_opc_d = 4'h0;
            hold_d    = 1'b1;
            state_d   = StHi;
          end else if (len_big) begin
            err_d     = 1'b1;
            err_opc_d = 4'h0;
            hold_d    = 1'b1;
            state_d   = StErr;
          end
        end
      end
      StHi: begin
        if (xfer) begin
          if (opc_legal) begin
            wdata_d[15:8] = in_data;
            state_d       = StLo;
          end else begin
            err_d     = 1'b1;
            err_opc_d = in_data[7:4];
            hold_d    = 1'b1;
            state_d   = StErr;
          end
        end
      end
      StLo: begin
        if (xfer) begin
          wdata_d[7:0] = in_data;
          state_d      = StWr;
        end
      end
      StWr: begin
        cnt_d  = cnt_inc;
        // Wraps to 0 after 2**ADDR_W words, but that address is never written.
        addr_d = addr_q + ADDR_W'(1);
        if (cnt_inc == len_q) begin
          hold_d  = 1'b0;
          state_d = StDone;
        end else begin
          state_d = StHi;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      err_opc_q <= 4'h0;
      hold_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      err_opc_q <= err_opc_d;
      hold_q    <= hold_d;
    end
  end

  assign imem_we    = (state_q == StWr);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == StHi) || (state_q == StLo) || (state_q == StWr);
  assign done       = (state_q == StDone);
  assign err        = err_q;
  assign err_opc    = err_opc_q;
  assign cpu_hold   = hold_q;

endmodule
